regwrite_queue: RTL and testbench



---
 rtl/regwrite_queue.sv | 135 +++++++++++++
 tb/tb_regwrite_queue.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regwrite_queue.sv
// Purpose : buffers writeback results and drains them one per cycle into the
//           register file write port; forwards queued values to two decode readers.
// Latency : entry pushed at edge N is presented on WriteReg/WriteData/hit* after
//           edge N and commits at the first later edge with rf_grant high.
// Backpressure: in_ready drops when all DEPTH entries are occupied, even if the
//           head is draining the same cycle (no pass-through).
//
// Ports:
//   clock, reset_n            clock, asynchronous active-low reset
//   in_valid/in_ready         writeback handshake, in_reg/in_data payload
//   flush                     discard every queued entry
//   rf_grant                  register-file write port available this cycle
//   RegWrite/WriteReg/WriteData  register-file write port
//   Read1/Read2 -> hit1/fwd1, hit2/fwd2   forwarding lookups (youngest match)
//   count                     entries currently queued
module regwrite_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ADDR_W-1:0]          in_reg,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       flush,
    input  logic                       rf_grant,
    output logic                       RegWrite,
    output logic [ADDR_W-1:0]          WriteReg,
    output logic [DATA_W-1:0]          WriteData,
    input  logic [ADDR_W-1:0]          Read1,
    input  logic [ADDR_W-1:0]          Read2,
    output logic                       hit1,
    output logic                       hit2,
    output logic [DATA_W-1:0]          fwd1,
    output logic [DATA_W-1:0]          fwd2,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    // XZR: architecturally hard-wired zero, never stored or forwarded.
    localparam logic [ADDR_W-1:0] XZR = ADDR_W'(31);

    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    // Entry storage carries no reset; validity is tracked by head/count only.
    logic [ADDR_W-1:0] reg_mem  [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    logic not_empty;
    logic push;
    logic pop;
    logic [PTR_W-1:0] fwd_idx;

    assign not_empty = (count_q != '0);
    assign in_ready  = (count_q != CNT_W'(DEPTH));
    // Writes to XZR are consumed by the handshake but dropped here.
    assign push      = in_valid && in_ready && !flush && (in_reg != XZR);
    assign pop       = not_empty && rf_grant && !flush;

    assign RegWrite  = pop;
    assign WriteReg  = not_empty ? reg_mem[head_q]  : '0;
    assign WriteData = not_empty ? data_mem[head_q] : '0;
    assign count     = count_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                tail_d = tail_q + 1'b1;
            end
            if (pop) begin
                head_d = head_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            reg_mem[tail_q]  <= in_reg;
            data_mem[tail_q] <= in_data;
        end
    end

    // Walk valid entries oldest to youngest so a later match overrides an
    // earlier one: the result is the most recent queued value for that index.
    always_comb begin
        hit1    = 1'b0;
        hit2    = 1'b0;
        fwd1    = '0;
        fwd2    = '0;
        fwd_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = head_q + PTR_W'(i);
            if (CNT_W'(i) < count_q) begin
                if ((reg_mem[fwd_idx] == Read1) && (Read1 != XZR)) begin
                    hit1 = 1'b1;
                    fwd1 = data_mem[fwd_idx];
                end
                if ((reg_mem[fwd_idx] == Read2) && (Read2 != XZR)) begin
                    hit2 = 1'b1;
                    fwd2 = data_mem[fwd_idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_regwrite_queue.sv
module tb_regwrite_queue;

    localparam int DEPTH = 4;

    logic        clock;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_reg;
    logic [63:0] in_data;
    logic        flush;
    logic        rf_grant;
    logic        RegWrite;
    logic [4:0]  WriteReg;
    logic [63:0] WriteData;
    logic [4:0]  Read1;
    logic [4:0]  Read2;
    logic        hit1;
    logic        hit2;
    logic [63:0] fwd1;
    logic [63:0] fwd2;
    logic [2:0]  count;

    int checks;
    int failures;

    typedef struct packed {
        logic [4:0]  r;
        logic [63:0] d;
    } ent_t;

    ent_t sb[$];

    regwrite_queue #(.DEPTH(DEPTH), .DATA_W(64), .ADDR_W(5)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_reg   (in_reg),
        .in_data  (in_data),
        .flush    (flush),
        .rf_grant (rf_grant),
        .RegWrite (RegWrite),
        .WriteReg (WriteReg),
        .WriteData(WriteData),
        .Read1    (Read1),
        .Read2    (Read2),
        .hit1     (hit1),
        .hit2     (hit2),
        .fwd1     (fwd1),
        .fwd2     (fwd2),
        .count    (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Scoreboard: expected writes queued when the handshake is modelled to
    // accept, popped and compared when the write port commits.
    always @(negedge clock) begin
        if (!reset_n) begin
            sb.delete();
        end else begin
            int  sz;
            logic exp_rw;
            logic accept;
            ent_t e;
            sz     = sb.size();
            accept = in_valid && (sz < DEPTH) && (in_reg != 5'd31);
            exp_rw = (sz != 0) && rf_grant && !flush;
            checks++;
            if (count !== 3'(sz)) begin
                failures++;
                $display("FAIL mon_count got=%0d exp=%0d t=%0t", count, sz, $time);
            end
            checks++;
            if (in_ready !== (sz < DEPTH)) begin
                failures++;
                $display("FAIL mon_in_ready got=%b exp=%b t=%0t", in_ready, (sz < DEPTH), $time);
            end
            checks++;
            if (RegWrite !== exp_rw) begin
                failures++;
                $display("FAIL mon_regwrite got=%b exp=%b t=%0t", RegWrite, exp_rw, $time);
            end
            if (sz != 0) begin
                e = sb[0];
                checks++;
                if (WriteReg !== e.r || WriteData !== e.d) begin
                    failures++;
                    $display("FAIL mon_head got=%0d/%h exp=%0d/%h t=%0t",
                             WriteReg, WriteData, e.r, e.d, $time);
                end
            end else begin
                checks++;
                if (WriteReg !== 5'd0 || WriteData !== 64'd0) begin
                    failures++;
                    $display("FAIL mon_empty_port got=%0d/%h exp=0/0 t=%0t",
                             WriteReg, WriteData, $time);
                end
            end
            if (flush) begin
                sb.delete();
            end else begin
                if (exp_rw) void'(sb.pop_front());
                if (accept) sb.push_back({in_reg, in_data});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic test_reset;
        reset_n = 1'b0;
        #2;
        checks++;
        if (count !== 3'd0 || in_ready !== 1'b1 || RegWrite !== 1'b0 ||
            WriteReg !== 5'd0 || WriteData !== 64'd0 || hit1 !== 1'b0 ||
            hit2 !== 1'b0 || fwd1 !== 64'd0 || fwd2 !== 64'd0) begin
            failures++;
            $display("FAIL reset_state got=cnt%0d rdy%b rw%b wr%0d h%b%b exp=cnt0 rdy1 rw0 wr0 h00",
                     count, in_ready, RegWrite, WriteReg, hit1, hit2);
        end
        @(posedge clock); #1;
        reset_n = 1'b1;
    endtask

    task automatic test_single;
        rf_grant = 1'b1;
        in_reg   = 5'd1;
        in_data  = 64'hA;
        in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(negedge clock);
        checks++;
        if (RegWrite !== 1'b1 || WriteReg !== 5'd1 || WriteData !== 64'hA || count !== 3'd1) begin
            failures++;
            $display("FAIL single_write got=rw%b %0d/%h cnt%0d exp=rw1 1/a cnt1",
                     RegWrite, WriteReg, WriteData, count);
        end
        @(posedge clock); #1;
        checks++;
        if (count !== 3'd0) begin
            failures++;
            $display("FAIL single_drained got=%0d exp=0", count);
        end
        rf_grant = 1'b0;
    endtask

    task automatic test_fill_forward;
        logic [4:0] fr [4];
        fr[0] = 5'd2; fr[1] = 5'd3; fr[2] = 5'd2; fr[3] = 5'd4;
        rf_grant = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_reg   = fr[k];
            in_data  = 64'(k + 5);
            in_valid = 1'b1;
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
        Read1 = 5'd2;
        Read2 = 5'd9;
        #1;
        checks++;
        if (in_ready !== 1'b0 || count !== 3'd4) begin
            failures++;
            $display("FAIL full_state got=rdy%b cnt%0d exp=rdy0 cnt4", in_ready, count);
        end
        checks++;
        if (hit1 !== 1'b1 || fwd1 !== 64'd7) begin
            failures++;
            $display("FAIL fwd_youngest got=%b/%h exp=1/7", hit1, fwd1);
        end
        checks++;
        if (hit2 !== 1'b0 || fwd2 !== 64'd0) begin
            failures++;
            $display("FAIL fwd_miss got=%b/%h exp=0/0", hit2, fwd2);
        end
        Read1 = 5'd3;
        Read2 = 5'd4;
        #1;
        checks++;
        if (hit1 !== 1'b1 || fwd1 !== 64'd6 || hit2 !== 1'b1 || fwd2 !== 64'd8) begin
            failures++;
            $display("FAIL fwd_other got=%b/%h %b/%h exp=1/6 1/8", hit1, fwd1, hit2, fwd2);
        end
        // Offer a write while full and draining: must not pass through.
        rf_grant = 1'b1;
        in_reg   = 5'd10;
        in_data  = 64'h99;
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            checks++;
            if (RegWrite !== 1'b1 || WriteReg !== fr[k] || WriteData !== 64'(k + 5)) begin
                failures++;
                $display("FAIL drain_order[%0d] got=rw%b %0d/%h exp=rw1 %0d/%h",
                         k, RegWrite, WriteReg, WriteData, fr[k], k + 5);
            end
            if (k == 0) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL full_pop_ready got=%b exp=0", in_ready);
                end
            end
            @(posedge clock); #1;
            in_valid = 1'b0;
        end
        checks++;
        if (count !== 3'd0 || RegWrite !== 1'b0) begin
            failures++;
            $display("FAIL drain_done got=cnt%0d rw%b exp=cnt0 rw0", count, RegWrite);
        end
        rf_grant = 1'b0;
    endtask

    task automatic test_xzr;
        rf_grant = 1'b1;
        in_reg   = 5'd31;
        in_data  = 64'hFF;
        in_valid = 1'b1;
        Read1    = 5'd31;
        @(negedge clock);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL xzr_ready got=%b exp=1", in_ready);
        end
        @(posedge clock); #1;
        in_valid = 1'b0;
        checks++;
        if (count !== 3'd0 || RegWrite !== 1'b0 || hit1 !== 1'b0) begin
            failures++;
            $display("FAIL xzr_dropped got=cnt%0d rw%b hit%b exp=cnt0 rw0 hit0",
                     count, RegWrite, hit1);
        end
        @(posedge clock); #1;
        checks++;
        if (RegWrite !== 1'b0) begin
            failures++;
            $display("FAIL xzr_no_write got=%b exp=0", RegWrite);
        end
        rf_grant = 1'b0;
    endtask

    task automatic test_back_to_back;
        int nw;
        nw = 0;
        rf_grant = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_reg   = 5'(i + 1);
            in_data  = 64'(i * 64'h111 + 1);
            in_valid = 1'b1;
            @(negedge clock);
            if (RegWrite === 1'b1) nw++;
            checks++;
            if (count > 3'd1) begin
                failures++;
                $display("FAIL b2b_count[%0d] got=%0d exp<=1", i, count);
            end
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
        @(negedge clock);
        if (RegWrite === 1'b1) nw++;
        @(posedge clock); #1;
        checks++;
        if (nw != 10 || count !== 3'd0) begin
            failures++;
            $display("FAIL b2b_writes got=%0d cnt%0d exp=10 cnt0", nw, count);
        end
        rf_grant = 1'b0;
    endtask

    task automatic test_flush;
        rf_grant = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_reg   = 5'(k + 1);
            in_data  = 64'(16 * (k + 1));
            in_valid = 1'b1;
            @(posedge clock); #1;
        end
        in_reg   = 5'd5;
        in_data  = 64'h55;
        in_valid = 1'b1;
        flush    = 1'b1;
        rf_grant = 1'b1;
        Read1    = 5'd5;
        Read2    = 5'd1;
        @(negedge clock);
        checks++;
        if (RegWrite !== 1'b0 || count !== 3'd3 || hit2 !== 1'b1 || fwd2 !== 64'h10) begin
            failures++;
            $display("FAIL flush_cycle got=rw%b cnt%0d h2%b/%h exp=rw0 cnt3 h2 1/10",
                     RegWrite, count, hit2, fwd2);
        end
        @(posedge clock); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (count !== 3'd0 || RegWrite !== 1'b0 || hit1 !== 1'b0 || hit2 !== 1'b0 ||
            fwd1 !== 64'd0 || fwd2 !== 64'd0) begin
            failures++;
            $display("FAIL flush_after got=cnt%0d rw%b h%b%b exp=cnt0 rw0 h00",
                     count, RegWrite, hit1, hit2);
        end
        @(posedge clock); #1;
        checks++;
        if (RegWrite !== 1'b0 || count !== 3'd0) begin
            failures++;
            $display("FAIL flush_no_x5 got=rw%b cnt%0d exp=rw0 cnt0", RegWrite, count);
        end
        rf_grant = 1'b0;
    endtask

    task automatic test_async_reset;
        rf_grant = 1'b0;
        in_reg = 5'd6; in_data = 64'h66; in_valid = 1'b1;
        @(posedge clock); #1;
        in_reg = 5'd7; in_data = 64'h77;
        @(posedge clock); #1;
        in_valid = 1'b0;
        Read1 = 5'd6;
        Read2 = 5'd7;
        rf_grant = 1'b1;
        #1;
        checks++;
        if (count !== 3'd2 || RegWrite !== 1'b1 || hit1 !== 1'b1 || fwd1 !== 64'h66) begin
            failures++;
            $display("FAIL pre_reset got=cnt%0d rw%b h1%b/%h exp=cnt2 rw1 1/66",
                     count, RegWrite, hit1, fwd1);
        end
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if (count !== 3'd0 || in_ready !== 1'b1 || RegWrite !== 1'b0 ||
            WriteReg !== 5'd0 || WriteData !== 64'd0 || hit1 !== 1'b0 ||
            hit2 !== 1'b0 || fwd1 !== 64'd0 || fwd2 !== 64'd0) begin
            failures++;
            $display("FAIL async_reset got=cnt%0d rdy%b rw%b wr%0d/%h h%b%b exp=all zero rdy1",
                     count, in_ready, RegWrite, WriteReg, WriteData, hit1, hit2);
        end
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;
        checks++;
        if (count !== 3'd0 || RegWrite !== 1'b0) begin
            failures++;
            $display("FAIL post_reset got=cnt%0d rw%b exp=cnt0 rw0", count, RegWrite);
        end
        rf_grant = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_reg   = 5'd0;
        in_data  = 64'd0;
        flush    = 1'b0;
        rf_grant = 1'b0;
        Read1    = 5'd0;
        Read2    = 5'd0;

        test_reset();
        test_single();
        test_fill_forward();
        test_xzr();
        test_back_to_back();
        test_flush();
        test_async_reset();

        @(negedge clock);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_empty got=%0d exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
